// File: rtl/spram_frame_arbiter_pkg.sv
// Shared types, image geometry and colour helpers for the SPRAM frame arbiter.
package spram_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } arb_state_e;

    localparam int DEF_IMG_W_LOG2 = 7;
    localparam int DEF_IMG_H_LOG2 = 7;
    localparam int DEF_IMG_W      = 1 << DEF_IMG_W_LOG2;
    localparam int DEF_IMG_H      = 1 << DEF_IMG_H_LOG2;
    localparam int DEF_ADDR_W     = DEF_IMG_W_LOG2 + DEF_IMG_H_LOG2;
    localparam int DEF_FIFO_DEPTH = 8;

    localparam int PIXEL_W      = 16;
    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_B_MSB = 4;

    // Keep the two most significant bits of each RGB565 channel.
    function automatic logic [5:0] rgb565_to_rgb222(input logic [PIXEL_W-1:0] px);
        return {px[RGB565_R_MSB -: 2], px[RGB565_G_MSB -: 2], px[RGB565_B_MSB -: 2]};
    endfunction

endpackage

// File: rtl/spram_frame_arbiter_if.sv
// Camera, VGA and SPRAM signals shared between the arbiter and its environment.
interface spram_frame_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              enable;
    logic              cam_valid;
    logic [15:0]       cam_data;
    logic              cam_frame_done;
    logic              vga_valid;
    logic [9:0]        vga_row;
    logic [9:0]        vga_col;
    logic [ADDR_W-1:0] spram_ad;
    logic [15:0]       spram_di;
    logic              spram_we;
    logic [15:0]       spram_do;
    logic [5:0]        rgb_out;
    logic              rgb_valid;
    logic              fifo_overflow;

    modport master (
        output enable, cam_valid, cam_data, cam_frame_done,
        output vga_valid, vga_row, vga_col, spram_do,
        input  spram_ad, spram_di, spram_we, rgb_out, rgb_valid, fifo_overflow
    );

    modport slave (
        input  enable, cam_valid, cam_data, cam_frame_done,
        input  vga_valid, vga_row, vga_col, spram_do,
        output spram_ad, spram_di, spram_we, rgb_out, rgb_valid, fifo_overflow
    );
endinterface

// File: rtl/spram_frame_arbiter_pixel_wr_fifo.sv
// Small synchronous FIFO that buffers {address, pixel} camera writes while the
// VGA path owns the SPRAM port.
module spram_frame_arbiter_pixel_wr_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign wr_en_s = push_i && !full_o;
    assign rd_en_s = pop_i && !empty_o;

    // Read/write pointers with synchronous flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s && !flush_i) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/spram_frame_arbiter.sv
// Shares the single-port frame buffer between camera writes and VGA reads;
// VGA reads win inside the image window, buffered camera writes fill the gaps.
module spram_frame_arbiter
    import spram_frame_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int IMG_W_LOG2 = DEF_IMG_W_LOG2,
    parameter int IMG_H_LOG2 = DEF_IMG_H_LOG2,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    spram_frame_arbiter_if.slave  bus
);
    localparam int ENTRY_W = ADDR_W + PIXEL_W;
    localparam int IMG_W   = 1 << IMG_W_LOG2;
    localparam int IMG_H   = 1 << IMG_H_LOG2;

    arb_state_e          state_q;
    logic [ADDR_W:0]     push_addr_q;
    logic [ADDR_W:0]     push_addr_d;
    logic [ADDR_W-1:0]   spram_ad_q;
    logic [PIXEL_W-1:0]  spram_di_q;
    logic                spram_we_q;
    logic                overflow_q;
    logic                win1_q;
    logic                win2_q;
    logic                rgb_valid_q;
    logic [5:0]          rgb_out_q;

    logic                in_win_s;
    logic                run_s;
    logic                read_s;
    logic                addr_sat_s;
    logic                push_s;
    logic                drop_s;
    logic                pop_s;
    logic                flush_s;
    logic                full_s;
    logic                empty_s;
    logic [ENTRY_W-1:0]  push_entry_s;
    logic [ENTRY_W-1:0]  pop_entry_s;

    assign in_win_s     = bus.vga_valid &&
                          (bus.vga_row < 10'(IMG_H)) &&
                          (bus.vga_col < 10'(IMG_W));
    assign run_s        = (state_q == ST_RUN) && bus.enable;
    assign read_s       = run_s && in_win_s;
    assign addr_sat_s   = push_addr_q[ADDR_W];
    assign push_s       = run_s && bus.cam_valid && !addr_sat_s && !full_s;
    assign drop_s       = run_s && bus.cam_valid && !addr_sat_s && full_s;
    assign pop_s        = run_s && !in_win_s && !empty_s;
    assign flush_s      = !bus.enable || (state_q != ST_RUN);
    assign push_entry_s = {push_addr_q[ADDR_W-1:0], bus.cam_data};

    spram_frame_arbiter_pixel_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush_s),
        .push_i  (push_s),
        .data_i  (push_entry_s),
        .pop_i   (pop_s),
        .data_o  (pop_entry_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Next camera address: frame done rewinds, a saturated counter stays put.
    always_comb begin
        push_addr_d = push_addr_q;
        if (!bus.enable) begin
            push_addr_d = '0;
        end else if (bus.cam_frame_done && (state_q != ST_IDLE)) begin
            push_addr_d = '0;
        end else if (run_s && bus.cam_valid && !addr_sat_s) begin
            push_addr_d = push_addr_q + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            push_addr_d = push_addr_q;
        end
    end

    // State machine, port grant and the three-stage read colour pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            push_addr_q <= '0;
            spram_ad_q  <= '0;
            spram_di_q  <= '0;
            spram_we_q  <= 1'b0;
            overflow_q  <= 1'b0;
            win1_q      <= 1'b0;
            win2_q      <= 1'b0;
            rgb_valid_q <= 1'b0;
            rgb_out_q   <= 6'd0;
        end else begin
            push_addr_q <= push_addr_d;
            win1_q      <= read_s;
            win2_q      <= win1_q;
            rgb_valid_q <= win2_q;
            rgb_out_q   <= win2_q ? rgb565_to_rgb222(bus.spram_do) : 6'd0;

            if (!bus.enable) begin
                state_q    <= ST_IDLE;
                spram_we_q <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q    <= ST_SYNC;
                        spram_we_q <= 1'b0;
                    end
                    ST_SYNC: begin
                        state_q    <= bus.cam_frame_done ? ST_RUN : ST_SYNC;
                        spram_we_q <= 1'b0;
                    end
                    ST_RUN: begin
                        state_q <= ST_RUN;
                        if (drop_s) begin
                            overflow_q <= 1'b1;
                        end
                        if (read_s) begin
                            spram_ad_q <= {bus.vga_row[IMG_H_LOG2-1:0],
                                           bus.vga_col[IMG_W_LOG2-1:0]};
                            spram_we_q <= 1'b0;
                        end else if (pop_s) begin
                            spram_ad_q <= pop_entry_s[ENTRY_W-1:PIXEL_W];
                            spram_di_q <= pop_entry_s[PIXEL_W-1:0];
                            spram_we_q <= 1'b1;
                        end else begin
                            spram_we_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        spram_we_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.spram_ad      = spram_ad_q;
    assign bus.spram_di      = spram_di_q;
    assign bus.spram_we      = spram_we_q;
    assign bus.rgb_out       = rgb_out_q;
    assign bus.rgb_valid     = rgb_valid_q;
    assign bus.fifo_overflow = overflow_q;

endmodule
